// File: rtl/console_pkg.sv
// Shared types and constants for the console UART transmitter.
package console_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/console_fifo.sv
// Synchronous byte FIFO with full-width occupancy count.
module console_fifo #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign dout = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/console_tx.sv
// Captures core print events into a FIFO and sends them as 8N1 UART.
module console_tx
   import console_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             print_flag,
   input  logic [7:0]       char_in,
   input  logic             halt,
   output logic             uart_tx,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow,
   output logic             halt_done
);

   localparam int BC_W  = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_BITS);

   tx_state_t        state;
   logic             pf_q;
   logic             evt;
   logic             push;
   logic             pop;
   logic             bit_end;
   logic             halt_seen;
   logic [7:0]       head;
   logic [7:0]       shift;
   logic [BC_W-1:0]  bit_cnt;
   logic [IDX_W-1:0] bit_idx;

   assign evt     = print_flag ^ pf_q;
   assign pop     = (state == IDLE) && (fifo_count != '0);
   assign push    = evt && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
   assign bit_end = (bit_cnt == BC_W'(CLKS_PER_BIT - 1));
   assign busy    = (state != IDLE) || (fifo_count != '0);

   console_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (char_in),
      .dout  (head),
      .count (fifo_count)
   );

   // pf_q tracks the level even in reset so release fires no event.
   always_ff @(posedge clk) begin
      pf_q <= print_flag;
      if (!rst) begin
         overflow  <= 1'b0;
         halt_seen <= 1'b0;
         halt_done <= 1'b0;
      end else begin
         if (evt && !push) overflow <= 1'b1;
         if (halt) halt_seen <= 1'b1;
         if (halt_seen && (fifo_count == '0) && (state == IDLE))
            halt_done <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         uart_tx <= IDLE_LEVEL;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               uart_tx <= IDLE_LEVEL;
               bit_cnt <= '0;
               bit_idx <= '0;
               if (pop) begin
                  shift   <= head;
                  uart_tx <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  uart_tx <= shift[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                     uart_tx <= IDLE_LEVEL;
                     state   <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     uart_tx <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_console_tx.sv
// Directed self-checking bench for console_tx (4 clocks per bit, depth 8).
module tb_console_tx;

   localparam int CPB = 4;
   localparam int PER = 10 * CPB + 1;

   logic       clk;
   logic       rst;
   logic       print_flag;
   logic [7:0] char_in;
   logic       halt;
   logic       uart_tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       halt_done;

   int n_run;
   int n_fail;
   int cyc;
   int t0;

   console_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .print_flag (print_flag),
      .char_in    (char_in),
      .halt       (halt),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .halt_done  (halt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // t0 is the edge at which the start bit goes low.
   task automatic rx_frame(input int t0f, input logic [7:0] exp,
                           input bit gap_chk, input string tag);
      logic [7:0] rx;
      if (gap_chk) begin
         wait_until(t0f - 1);
         chk({tag, " gap"}, 32'(uart_tx), 1);
         wait_until(t0f);
         chk({tag, " start_edge"}, 32'(uart_tx), 0);
      end
      wait_until(t0f + CPB / 2);
      chk({tag, " start"}, 32'(uart_tx), 0);
      for (int b = 0; b < 8; b++) begin
         wait_until(t0f + CPB / 2 + CPB * (b + 1));
         rx[b] = uart_tx;
      end
      chk({tag, " data"}, 32'(rx), 32'(exp));
      wait_until(t0f + CPB * 9 + CPB / 2);
      chk({tag, " stop"}, 32'(uart_tx), 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      n_run      = 0;
      n_fail     = 0;
      rst        = 1'b0;
      print_flag = 1'b0;
      char_in    = 8'h00;
      halt       = 1'b0;
      repeat (3) tick();
      chk("rst uart_tx", 32'(uart_tx), 1);
      chk("rst busy", 32'(busy), 0);
      chk("rst count", 32'(fifo_count), 0);
      chk("rst overflow", 32'(overflow), 0);
      chk("rst halt_done", 32'(halt_done), 0);
      rst = 1'b1;
      tick();
      chk("rel count", 32'(fifo_count), 0);

      // single character 'A'
      print_flag = ~print_flag;
      char_in    = 8'h41;
      tick();
      chk("one e0 count", 32'(fifo_count), 1);
      chk("one e0 uart", 32'(uart_tx), 1);
      chk("one e0 busy", 32'(busy), 1);
      tick();
      t0 = cyc;
      chk("one e1 uart", 32'(uart_tx), 0);
      chk("one e1 count", 32'(fifo_count), 0);
      rx_frame(t0, 8'h41, 1'b0, "one");
      wait_until(t0 + 10 * CPB - 1);
      chk("one busy stop", 32'(busy), 1);
      wait_until(t0 + 10 * CPB);
      chk("one busy end", 32'(busy), 0);
      chk("one uart end", 32'(uart_tx), 1);

      // overflow burst of ten characters
      tick();
      for (int k = 0; k < 10; k++) begin
         print_flag = ~print_flag;
         char_in    = 8'h30 + 8'(k);
         tick();
         if (k == 1) t0 = cyc;
         if (k == 8) begin
            chk("burst cnt9th", 32'(fifo_count), 8);
            chk("burst ovf9th", 32'(overflow), 0);
         end
      end
      chk("burst cnt10th", 32'(fifo_count), 8);
      chk("burst ovf10th", 32'(overflow), 1);
      for (int k = 0; k < 9; k++)
         rx_frame(t0 + PER * k, 8'h30 + 8'(k), k > 0, "burst");
      wait_until(t0 + PER * 9);
      chk("burst no10 uart", 32'(uart_tx), 1);
      chk("burst no10 busy", 32'(busy), 0);
      chk("burst ovf sticky", 32'(overflow), 1);

      // full FIFO accepting a byte on the pop cycle
      do_reset();
      tick();
      chk("full ovf clr", 32'(overflow), 0);
      for (int k = 0; k < 9; k++) begin
         print_flag = ~print_flag;
         char_in    = 8'h50 + 8'(k);
         tick();
         if (k == 1) t0 = cyc;
      end
      chk("full cnt", 32'(fifo_count), 8);
      rx_frame(t0, 8'h50, 1'b0, "full0");
      wait_until(t0 + 10 * CPB);
      chk("full cnt idle", 32'(fifo_count), 8);
      print_flag = ~print_flag;
      char_in    = 8'h59;
      tick();
      chk("full pop cnt", 32'(fifo_count), 8);
      chk("full pop ovf", 32'(overflow), 0);
      chk("full pop uart", 32'(uart_tx), 0);
      for (int k = 1; k < 10; k++)
         rx_frame(t0 + PER * k, 8'h50 + 8'(k), k > 1, "full");

      // halt with pending output
      do_reset();
      tick();
      for (int k = 0; k < 3; k++) begin
         print_flag = ~print_flag;
         char_in    = 8'h61 + 8'(k);
         tick();
         if (k == 1) t0 = cyc;
      end
      halt = 1'b1;
      tick();
      chk("halt early", 32'(halt_done), 0);
      for (int k = 0; k < 3; k++)
         rx_frame(t0 + PER * k, 8'h61 + 8'(k), k > 0, "halt");
      wait_until(t0 + 2 * PER + 10 * CPB);
      chk("halt stop end", 32'(halt_done), 0);
      wait_until(t0 + 2 * PER + 10 * CPB + 1);
      chk("halt done", 32'(halt_done), 1);
      halt = 1'b0;
      repeat (5) tick();
      chk("halt sticky", 32'(halt_done), 1);

      // reset in the middle of a frame
      for (int k = 0; k < 3; k++) begin
         print_flag = ~print_flag;
         char_in    = 8'h71 + 8'(k);
         tick();
         if (k == 1) t0 = cyc;
      end
      wait_until(t0 + CPB + 6);
      chk("mid cnt", 32'(fifo_count), 2);
      rst = 1'b0;
      tick();
      chk("mid uart", 32'(uart_tx), 1);
      chk("mid count", 32'(fifo_count), 0);
      chk("mid ovf", 32'(overflow), 0);
      chk("mid busy", 32'(busy), 0);
      chk("mid halt_done", 32'(halt_done), 0);
      print_flag = ~print_flag;
      char_in    = 8'h7a;
      tick();
      rst = 1'b1;
      tick();
      chk("held count", 32'(fifo_count), 0);
      repeat (3) tick();
      chk("held uart", 32'(uart_tx), 1);
      chk("held busy", 32'(busy), 0);

      // rising then falling print_flag
      for (int k = 0; k < 2; k++) begin
         print_flag = ~print_flag;
         char_in    = 8'h68 + 8'(k);
         tick();
         if (k == 1) begin
            t0 = cyc;
            chk("both cnt", 32'(fifo_count), 1);
         end
      end
      rx_frame(t0, 8'h68, 1'b0, "both h");
      rx_frame(t0 + PER, 8'h69, 1'b1, "both i");
      wait_until(t0 + PER + 10 * CPB);
      chk("both idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
